dds_sine_gen: RTL and testbench

Parametrised direct-digital-synthesis sine generator: a phase accumulator driven by a run-time frequency tuning word (FTW) addresses a quarter-wave ROM, and the result is reconstructed to a full signed sine wave and amplitude-scaled. It replaces the fixed 100-sample table generator as the waveform source for the DAC path and the signal-processing testbenches. FTW updates are glitch-free: a new FTW takes effect only on an accumulator wrap.

---
 rtl/dds_sine_gen.sv | 127 ++++++++++++
 tb/tb_dds_sine_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: DDS sine source with phase accumulator, quarter-wave ROM, sign reconstruction and amplitude scaling
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    advance accumulator by the active tuning word
//   phase_clr             synchronous accumulator clear, overrides en
//   ftw/ftw_valid/ftw_ready  tuning-word handshake, one-entry pending register
//   phase_off             static phase offset added after the accumulator
//   amp                   unsigned amplitude scale (used only with DDS_AMP_SCALE_EN)
//   dout/dout_valid       signed sample and its enabled-cycle flag
//   wrap                  pulse aligned with the first sample of a new period
// Build option: define DDS_AMP_SCALE_EN to instantiate the amplitude multiplier;
// without it dout is the unscaled sample and amp is ignored.
module dds_sine_gen #(
    parameter int OUT_W   = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6,
    parameter int AMP_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    phase_clr,
    input  logic [PHASE_W-1:0]      ftw,
    input  logic                    ftw_valid,
    output logic                    ftw_ready,
    input  logic [PHASE_W-1:0]      phase_off,
    input  logic [AMP_W-1:0]        amp,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    wrap
);
    localparam int DEPTH = 2 ** LUT_AW;

    // Elaboration-time sine; the half-sample offset keeps every entry non-zero
    // so mirroring (~idx) and negation reproduce the full wave exactly.
    function automatic logic [OUT_W-2:0] rom_val(input int k);
        real x, t, s;
        x = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
        t = x;
        s = x;
        for (int n = 1; n < 12; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return (OUT_W-1)'($rtoi(s * real'(2 ** (OUT_W - 1) - 1) + 0.5));
    endfunction

    logic [OUT_W-2:0] rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [OUT_W-2:0] V = rom_val(i);
        assign rom[i] = V;
    end

    logic [PHASE_W-1:0]      acc_q, acc_d, act_q, act_d, pend_q, pend_d, sum, ph;
    logic                    full_q, full_d, carry, wrap_ev, accept, apply;
    logic [LUT_AW-1:0]       idx, addr_q, addr_d;
    logic                    neg1_q, neg2_q;
    logic [OUT_W-2:0]        rom_q;
    logic signed [OUT_W-1:0] s, dout_q, dout_d;
    logic [2:0]              vld_q;
    logic [3:0]              wrp_q;
    logic                    unused_ph;

    always_comb begin
        {carry, sum} = {1'b0, acc_q} + {1'b0, act_q};
        wrap_ev      = en && !phase_clr && carry;
        acc_d        = phase_clr ? '0 : en ? sum : acc_q;
        // A word accepted on a wrap cycle sees full_q=0 here, so it waits for the next event.
        accept       = ftw_valid && !full_q;
        apply        = full_q && (wrap_ev || act_q == '0 || !en || phase_clr);
        act_d        = apply ? pend_q : act_q;
        pend_d       = accept ? ftw : pend_q;
        full_d       = accept || (full_q && !apply);
        ph           = acc_q + phase_off;
        idx          = ph[PHASE_W-3 -: LUT_AW];
        addr_d       = ph[PHASE_W-2] ? ~idx : idx;
        s            = neg2_q ? -$signed({1'b0, rom_q}) : $signed({1'b0, rom_q});
    end

    // Phase bits below the ROM index are intentionally dropped.
    assign unused_ph = ^ph;

`ifdef DDS_AMP_SCALE_EN
    logic signed [OUT_W+AMP_W-1:0] prod;
    assign prod   = (OUT_W+AMP_W)'(s) * (OUT_W+AMP_W)'($signed({1'b0, amp}));
    assign dout_d = OUT_W'(prod >>> AMP_W);
`else
    logic unused_amp;
    assign unused_amp = ^amp;
    assign dout_d     = s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            act_q  <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
            addr_q <= '0;
            neg1_q <= 1'b0;
            rom_q  <= '0;
            neg2_q <= 1'b0;
            dout_q <= '0;
            vld_q  <= '0;
            wrp_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            full_q <= full_d;
            addr_q <= addr_d;
            neg1_q <= ph[PHASE_W-1];
            rom_q  <= rom[addr_q];
            neg2_q <= neg1_q;
            dout_q <= dout_d;
            // en tags the sample of the current accumulator value (3 stages);
            // the wrap carry tags the next value, hence one extra stage.
            vld_q  <= {vld_q[1:0], en};
            wrp_q  <= {wrp_q[2:0], wrap_ev};
        end
    end

    assign ftw_ready  = !full_q;
    assign dout       = dout_q;
    assign dout_valid = vld_q[2];
    assign wrap       = wrp_q[3];
endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: directed bench for dds_sine_gen with hand-computed sine samples
module tb_dds_sine_gen;
    logic              clk = 1'b0;
    logic              rst_n, en, phase_clr, ftw_valid, ftw_ready, dout_valid, wrap;
    logic [15:0]       ftw, phase_off;
    logic [7:0]        amp;
    logic signed [7:0] dout;
    int                total = 0;
    int                bad = 0;
    int                e, a;
    bit                h;

    always #5 clk = ~clk;

    dds_sine_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .ftw       (ftw),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .phase_off (phase_off),
        .amp       (amp),
        .dout      (dout),
        .dout_valid(dout_valid),
        .wrap      (wrap)
    );

    function automatic int sc(input int v);
`ifdef DDS_AMP_SCALE_EN
        return (v * int'(amp)) >>> 8;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clear the accumulator and advance until dout shows the phase-0 sample.
    task automatic clr();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw = '0; ftw_valid = 1'b0;
        phase_off = '0; amp = 8'd255;
        repeat (3) tick();
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_ready", int'(ftw_ready), 1);

        // FTW=0: constant ROM[0], valid three cycles after en
        rst_n = 1'b1; en = 1'b1;
        tick();
        chk("fill1_dout", int'(dout), 0);
        chk("fill1_valid", int'(dout_valid), 0);
        tick();
        chk("fill2_valid", int'(dout_valid), 0);
        tick();
        chk("first_dout", int'(dout), sc(2));
        chk("first_valid", int'(dout_valid), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ftw0_dout", int'(dout), sc(2));
            chk("ftw0_wrap", int'(wrap), 0);
        end

        // Load FTW=1024 while active word is 0: applied on the next edge
        ftw = 16'd1024; ftw_valid = 1'b1;
        chk("ready_idle", int'(ftw_ready), 1);
        tick();
        ftw_valid = 1'b0;
        chk("ready_drop", int'(ftw_ready), 0);
        tick();
        chk("ready_back", int'(ftw_ready), 1);
        clr();

        // t indexes dout samples; the accumulator runs 3 cycles ahead (a = t+3).
        // FTW=2048 offered at a=10, applied at the wrap after a=63;
        // FTW=1024 offered on the wrap cycle a=95, deferred to the wrap after a=127.
        for (int t = 0; t <= 150; t++) begin
            a = t + 3; h = 1'b1; e = 0;
            case (t)
                0, 64, 96, 128: e = 2;
                1, 129:         e = 14;
                16, 72, 144:    e = 127;
                32, 80, 112:    e = -2;
                48, 88:         e = -127;
                63:             e = -11;
                65:             e = 26;
                default:        h = 1'b0;
            endcase
            if (h) chk($sformatf("sine@%0d", t), int'(dout), sc(e));
            chk($sformatf("wrap@%0d", t), int'(wrap), int'(t == 64 || t == 96 || t == 128));
            chk($sformatf("ready@%0d", t), int'(ftw_ready),
                int'(!((a >= 11 && a <= 63) || (a >= 96 && a <= 127))));
            chk($sformatf("valid@%0d", t), int'(dout_valid), 1);
            ftw_valid = (t == 7 || t == 92);
            ftw = (t == 7) ? 16'd2048 : 16'd1024;
            tick();
        end
        ftw_valid = 1'b0;

        // Quarter-period offset gives a cosine
        phase_off = 16'h4000;
        clr();
        chk("cos0", int'(dout), sc(127));
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j == 1) chk("cos1", int'(dout), sc(126));
            if (j == 16) chk("cos16", int'(dout), sc(-2));
            if (j == 32) chk("cos32", int'(dout), sc(-127));
            chk("cos_wrap", int'(wrap), 0);
        end
        clr();
        chk("clr_cos", int'(dout), sc(127));
        chk("clr_wrap", int'(wrap), 0);

        // Amplitude scaling (unity when the multiplier is not built)
        amp = 8'd128;
        clr();
        chk("amp128_peak", int'(dout), sc(127));
        repeat (32) tick();
        chk("amp128_trough", int'(dout), sc(-127));
        amp = 8'd0;
        tick();
        chk("amp0_j33", int'(dout), sc(-126));
        repeat (15) tick();
        chk("amp0_j48", int'(dout), sc(2));
        amp = 8'd255;

        // en=0: phase holds at offset 0x4000, samples repeat with valid low
        en = 1'b0;
        clr();
        chk("hold_dout", int'(dout), sc(127));
        chk("hold_valid", int'(dout_valid), 0);
        repeat (5) tick();
        chk("hold_dout2", int'(dout), sc(127));
        chk("hold_valid2", int'(dout_valid), 0);

        // With en=0 a new word is applied immediately
        ftw = 16'd2048; ftw_valid = 1'b1;
        tick();
        ftw_valid = 1'b0;
        chk("en0_ready_drop", int'(ftw_ready), 0);
        tick();
        chk("en0_ready_back", int'(ftw_ready), 1);

        // Pending word discarded by reset
        en = 1'b1;
        ftw = 16'd4096; ftw_valid = 1'b1;
        tick();
        ftw_valid = 1'b0;
        chk("pend_ready", int'(ftw_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(ftw_ready), 1);
        chk("arst_dout", int'(dout), 0);
        chk("arst_valid", int'(dout_valid), 0);
        phase_off = '0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_dout", int'(dout), sc(2));
            chk("post_rst_wrap", int'(wrap), 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
